bt_cmd_sched: RTL

//  Round-robin scheduler sharing the single snd_cmd serial command engine among
//  NUM_REQ requesters (init sequencer, next/prev track, volume buttons).

---
 rtl/bt_cmd_sched.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/bt_cmd_sched.sv
// bt_cmd_sched: round-robin arbiter that shares the snd_cmd serial command
// engine among NUM_REQ requesters. It latches the granted command, strobes
// send, then waits for resp_rcvd. If no response arrives it re-sends the
// command up to MAX_RETRY times and finally reports done or err to the
// requester that owned the command.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | arbitrate; latch grant index and its cmd_start/cmd_len
// ISSUE   | send strobe high for one cycle
// WAIT    | count toward timeout, watch resp_rcvd
// RELEASE | done/err pulse high, advance RR pointer past the grant
module bt_cmd_sched #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 100000,
  parameter int MAX_RETRY   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*5-1:0] req_start,
  input  logic [NUM_REQ*4-1:0] req_len,
  output logic [NUM_REQ-1:0]   done,
  output logic [NUM_REQ-1:0]   err,
  output logic                 busy,
  output logic                 send,
  output logic [4:0]           cmd_start,
  output logic [3:0]           cmd_len,
  input  logic                 resp_rcvd
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RELEASE
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0]      grant_q, grant_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [RW-1:0]      retry_q, retry_d;
  logic [TW-1:0]      tcnt_q, tcnt_d;
  logic [4:0]         start_d;
  logic [3:0]         len_d;
  logic               send_d, busy_d;
  logic [NUM_REQ-1:0] done_d, err_d;

  logic               arb_found;
  logic [IW-1:0]      arb_idx;
  logic [4:0]         arb_start;
  logic [3:0]         arb_len;

  // Round-robin search: first set req bit at or above the pointer, with wrap.
  always_comb begin
    int j;
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_start = '0;
    arb_len   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr_q) + i) % NUM_REQ;
      if (!arb_found && req[j]) begin
        arb_found = 1'b1;
        arb_idx   = IW'(j);
        arb_start = req_start[j*5 +: 5];
        arb_len   = req_len[j*4 +: 4];
      end
    end
  end

  // Next-state logic and next values of every registered output.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    retry_d = retry_q;
    tcnt_d  = tcnt_q;
    start_d = cmd_start;
    len_d   = cmd_len;
    send_d  = 1'b0;
    done_d  = '0;
    err_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          grant_d = arb_idx;
          start_d = arb_start;
          len_d   = arb_len;
          retry_d = '0;
          send_d  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A response here belongs to nothing we sent yet; it is dropped.
        tcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (resp_rcvd) begin
          done_d[grant_q] = 1'b1;
          state_d         = S_RELEASE;
        end else if (tcnt_q == TO_LAST) begin
          if (retry_q < RETRY_LIM) begin
            retry_d = retry_q + 1'b1;
            send_d  = 1'b1;
            state_d = S_ISSUE;
          end else begin
            err_d[grant_q] = 1'b1;
            state_d        = S_RELEASE;
          end
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        ptr_d   = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath and output registers; reset abandons any command in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q   <= '0;
      ptr_q     <= '0;
      retry_q   <= '0;
      tcnt_q    <= '0;
      cmd_start <= '0;
      cmd_len   <= '0;
      send      <= 1'b0;
      busy      <= 1'b0;
      done      <= '0;
      err       <= '0;
    end else begin
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      retry_q   <= retry_d;
      tcnt_q    <= tcnt_d;
      cmd_start <= start_d;
      cmd_len   <= len_d;
      send      <= send_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

endmodule
